terrain_carver: RTL and testbench

Destructive write-side counterpart to the terrain collision sampler: on a `start` pulse it carves a filled circle (crater) of given centre and radius out of the column-organised terrain memory by read-modify-write, clearing solid bits. It sits between game logic (explosion events) and the terrain column RAM. The RAM is 640 columns × 480-bit words, where bit y = 1 means solid. The collision sampler reads this same RAM.

---
 rtl/terrain_pkg.sv | 20 ++
 rtl/terrain_carver_span_mask.sv | 17 +
 rtl/terrain_carver.sv | 138 +++++++++++++
 tb/tb_terrain_carver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared terrain definitions for the column RAM and its reader/writer blocks.
package terrain_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned R_MAX    = 31;

  typedef logic [SCREEN_H-1:0] terrain_col_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HCALC,
    ST_READ,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } carver_state_t;

endpackage

// File: rtl/terrain_carver_span_mask.sv
// Combinational row-span mask: bits y_lo..y_hi set, all zero when y_lo > y_hi.
module column_span_mask
  import terrain_pkg::*;
(
  input  logic [9:0]   y_lo,
  input  logic [9:0]   y_hi,
  output terrain_col_t mask
);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < SCREEN_H; i++) begin
      mask[i] = (10'(i) >= y_lo) && (10'(i) <= y_hi);
    end
  end

endmodule

// File: rtl/terrain_carver.sv
// Carves a filled circle out of the column terrain RAM by per-column read-modify-write.
module terrain_carver
  import terrain_pkg::*;
#(
  parameter int unsigned SCREEN_W = terrain_pkg::SCREEN_W,
  parameter int unsigned SCREEN_H = terrain_pkg::SCREEN_H,
  parameter int unsigned R_MAX    = terrain_pkg::R_MAX
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [9:0]   cx,
  input  logic [9:0]   cy,
  input  logic [4:0]   radius,
  output logic         busy,
  output logic         done,
  output logic [9:0]   mem_addr,
  output logic         mem_rd,
  input  terrain_col_t mem_rdata,
  output logic         mem_wr,
  output terrain_col_t mem_wdata
);

  carver_state_t state;
  logic [9:0] cx_q, cy_q, x, x_hi_q;
  logic [4:0] r_q, h;

  logic signed [10:0] x_lo_s, dx, y_lo_s;
  logic [10:0] x_hi_s, y_hi_s;
  logic [9:0]  x_lo, x_hi, y_lo, y_hi;
  logic [4:0]  dx_mag;
  logic [9:0]  r_sq, dx_sq, h_sq, rem;
  terrain_col_t mask;

  // Bounds kept in 11 bits: the sign bit handles left/top clipping, and the
  // unsigned sums reach past 1023 before clamping.
  assign x_lo_s = $signed({1'b0, cx_q}) - $signed({6'b0, r_q});
  assign x_hi_s = {1'b0, cx_q} + {6'b0, r_q};
  assign x_lo   = x_lo_s[10] ? '0 : x_lo_s[9:0];
  assign x_hi   = (x_hi_s > 11'(SCREEN_W - 1)) ? 10'(SCREEN_W - 1) : x_hi_s[9:0];

  assign dx     = $signed({1'b0, x}) - $signed({1'b0, cx_q});
  assign dx_mag = dx[10] ? 5'(-dx) : dx[4:0];
  assign r_sq   = 10'(r_q) * 10'(r_q);
  assign dx_sq  = 10'(dx_mag) * 10'(dx_mag);
  assign h_sq   = 10'(h) * 10'(h);
  assign rem    = r_sq - dx_sq;

  assign y_lo_s = $signed({1'b0, cy_q}) - $signed({6'b0, h});
  assign y_hi_s = {1'b0, cy_q} + {6'b0, h};
  assign y_lo   = y_lo_s[10] ? '0 : y_lo_s[9:0];
  assign y_hi   = (y_hi_s > 11'(SCREEN_H - 1)) ? 10'(SCREEN_H - 1) : y_hi_s[9:0];

  column_span_mask u_mask (
    .y_lo (y_lo),
    .y_hi (y_hi),
    .mask (mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
      r_q       <= '0;
      x         <= '0;
      x_hi_q    <= '0;
      h         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cx_q  <= cx;
            cy_q  <= cy;
            r_q   <= (radius > 5'(R_MAX)) ? 5'(R_MAX) : radius;
            busy  <= 1'b1;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          x_hi_q <= x_hi;
          if (x_lo > x_hi) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            x     <= x_lo;
            h     <= r_q;
            state <= ST_HCALC;
          end
        end
        ST_HCALC: begin
          if (h_sq > rem) begin
            h <= h - 5'd1;
          end else begin
            mem_addr <= x;
            mem_rd   <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          mem_rd <= 1'b0;
          state  <= ST_WAIT;
        end
        // Read data is masked on capture, so the write data register doubles as the capture register.
        ST_WAIT: begin
          mem_wdata <= mem_rdata & ~mask;
          mem_wr    <= 1'b1;
          state     <= ST_WRITE;
        end
        ST_WRITE: begin
          mem_wr <= 1'b0;
          if (x == x_hi_q) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            x     <= x + 10'd1;
            h     <= r_q;
            state <= ST_HCALC;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_terrain_carver.sv
// Directed bench for terrain_carver with a 1-cycle-latency column RAM model.
module tb_terrain_carver;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [9:0]   cx = '0, cy = '0;
  logic [4:0]   radius = '0;
  logic         busy, done, mem_rd, mem_wr;
  logic [9:0]   mem_addr;
  logic [479:0] mem_wdata;
  logic [479:0] rdata_q = '0;

  logic [479:0] ram [0:639];
  int           wr_log [0:63];
  int           wr_count = 0, rd_count = 0, overlap = 0, bad_addr = 0;
  logic         tb_clear = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  terrain_carver #(.SCREEN_W(640), .SCREEN_H(480), .R_MAX(31)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cx        (cx),
    .cy        (cy),
    .radius    (radius),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (rdata_q),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 640; i++) ram[i] <= '1;
      wr_count <= 0;
      rd_count <= 0;
      overlap  <= 0;
      bad_addr <= 0;
    end else begin
      if (mem_rd) begin
        rd_count <= rd_count + 1;
        if (mem_addr < 10'd640) rdata_q <= ram[mem_addr];
      end
      if (mem_wr) begin
        if (mem_addr < 10'd640) ram[mem_addr] <= mem_wdata;
        if (wr_count < 64) wr_log[wr_count] <= int'(mem_addr);
        wr_count <= wr_count + 1;
      end
      if ((mem_rd || mem_wr) && mem_addr >= 10'd640) bad_addr <= bad_addr + 1;
      if (mem_rd && mem_wr) overlap <= overlap + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [479:0] got, input logic [479:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [479:0] make_col(input int lo, input int hi);
    logic [479:0] c;
    c = '1;
    for (int i = lo; i <= hi; i++) c[i] = 1'b0;
    return c;
  endfunction

  task automatic clear_ram();
    @(posedge clk); #1 tb_clear = 1'b1;
    @(posedge clk); #1 tb_clear = 1'b0;
  endtask

  // Pulses start right after edge 0; returns the cycle in which done is seen (-1 on timeout).
  task automatic run_carve(input int ccx, input int ccy, input int r, input int extra_at,
                           output int done_cyc, output logic busy1);
    done_cyc = -1;
    busy1 = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cx = 10'(ccx); cy = 10'(ccy); radius = 5'(r);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (k == 1) start = 1'b0;
      if (k == 1) busy1 = busy;
      if (extra_at != 0 && k == extra_at) begin
        start = 1'b1; cx = 10'd50; cy = 10'd50; radius = 5'd4;
      end
      if (extra_at != 0 && k == extra_at + 1) start = 1'b0;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  int   dc;
  logic b1;
  int   exp_lo [0:6] = '{240, 238, 238, 237, 238, 238, 240};
  int   exp_hi [0:6] = '{240, 242, 242, 243, 242, 242, 240};

  initial begin
    tb_clear = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy",  480'(busy),      480'(0));
    check_eq("rst_done",  480'(done),      480'(0));
    check_eq("rst_rd",    480'(mem_rd),    480'(0));
    check_eq("rst_wr",    480'(mem_wr),    480'(0));
    check_eq("rst_addr",  480'(mem_addr),  480'(0));
    check_eq("rst_wdata", mem_wdata,       480'(0));
    tb_clear = 1'b0;
    reset = 1'b1;

    // r = 0 single pixel
    clear_ram();
    run_carve(100, 200, 0, 0, dc, b1);
    check_eq("r0_done_cyc", 480'(dc), 480'(6));
    check_eq("r0_busy_c1",  480'(b1), 480'(1));
    @(posedge clk); #1;
    check_eq("r0_busy_fall", 480'(busy), 480'(0));
    check_eq("r0_wr_count",  480'(wr_count), 480'(1));
    check_eq("r0_wr_addr",   480'(wr_log[0]), 480'(100));
    check_eq("r0_col100",    ram[100], make_col(200, 200));
    check_eq("r0_col99",     ram[99], '1);

    // full crater r = 3
    clear_ram();
    run_carve(320, 240, 3, 0, dc, b1);
    @(posedge clk); #1;
    check_eq("r3_done_cyc", 480'(dc), 480'(40));
    check_eq("r3_wr_count", 480'(wr_count), 480'(7));
    check_eq("r3_rd_count", 480'(rd_count), 480'(7));
    check_eq("r3_overlap",  480'(overlap), 480'(0));
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("r3_addr%0d", i), 480'(wr_log[i]), 480'(317 + i));
      check_eq($sformatf("r3_col%0d", 317 + i), ram[317 + i], make_col(exp_lo[i], exp_hi[i]));
    end
    check_eq("r3_col316", ram[316], '1);
    check_eq("r3_col324", ram[324], '1);

    // left/top clipping
    clear_ram();
    run_carve(1, 2, 5, 0, dc, b1);
    @(posedge clk); #1;
    check_eq("lt_wr_count", 480'(wr_count), 480'(7));
    check_eq("lt_first",    480'(wr_log[0]), 480'(0));
    check_eq("lt_last",     480'(wr_log[6]), 480'(6));
    check_eq("lt_col1",     ram[1], make_col(0, 7));
    check_eq("lt_col0",     ram[0], make_col(0, 6));
    check_eq("lt_bad_addr", 480'(bad_addr), 480'(0));

    // right clipping
    clear_ram();
    run_carve(637, 100, 5, 0, dc, b1);
    @(posedge clk); #1;
    check_eq("rt_wr_count", 480'(wr_count), 480'(8));
    check_eq("rt_last",     480'(wr_log[7]), 480'(639));
    check_eq("rt_col639",   ram[639], make_col(96, 104));
    check_eq("rt_bad_addr", 480'(bad_addr), 480'(0));

    // fully out of range: no memory traffic, done within three cycles
    clear_ram();
    run_carve(700, 100, 5, 0, dc, b1);
    @(posedge clk); #1;
    check_eq("oor_rd",   480'(rd_count), 480'(0));
    check_eq("oor_wr",   480'(wr_count), 480'(0));
    check_eq("oor_done", 480'(dc >= 2 && dc <= 3), 480'(1));

    // second start while busy is ignored
    clear_ram();
    run_carve(320, 240, 3, 10, dc, b1);
    @(posedge clk); #1;
    check_eq("sb_done_cyc", 480'(dc), 480'(40));
    repeat (4) @(posedge clk);
    #1;
    check_eq("sb_busy_after", 480'(busy), 480'(0));
    check_eq("sb_wr_count",   480'(wr_count), 480'(7));
    check_eq("sb_col50",      ram[50], '1);

    // reset mid-carve, during the third column
    clear_ram();
    @(posedge clk); #1;
    start = 1'b1; cx = 10'd320; cy = 10'd240; radius = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 200 && wr_count < 2; k++) begin
      @(posedge clk); #1;
    end
    check_eq("mr_reach_col3", 480'(wr_count), 480'(2));
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check_eq("mr_busy", 480'(busy),     480'(0));
    check_eq("mr_rd",   480'(mem_rd),   480'(0));
    check_eq("mr_wr",   480'(mem_wr),   480'(0));
    check_eq("mr_addr", 480'(mem_addr), 480'(0));
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("mr_wr_count", 480'(wr_count), 480'(2));
    check_eq("mr_col317",   ram[317], make_col(240, 240));
    check_eq("mr_col319",   ram[319], '1);

    run_carve(100, 200, 0, 0, dc, b1);
    @(posedge clk); #1;
    check_eq("mr_after_done", 480'(dc), 480'(6));
    check_eq("mr_after_cnt",  480'(wr_count), 480'(3));
    check_eq("mr_after_col",  ram[100], make_col(200, 200));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
